tdm_demux8: RTL and testbench
=============================

TDM_DEMUX8 -- requirements
Module: tdm_demux8

Interface
REQ-001 SHALL have the clock and reset fixed as: one clock; reset is synchronous and active-high.
REQ-002 SHALL have port CLK, input, 1 bit: clock, all state updates on rising edge.
REQ-003 SHALL have port RST, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port EN, input, 1 bit: active-low enable; 1 freezes all state.
REQ-005 SHALL have port DIN, input, 1 bit: serial time-division data bit.
REQ-006 SHALL have port DVALID, input, 1 bit: DIN qualifier; bit accepted on an edge where EN=0 and DVALID=1.
REQ-007 SHALL have port SYNC, input, 1 bit: frame-start marker, meaningful only with an accepted bit.
REQ-008 SHALL have port Q, output, 8 bits: registered demultiplexed frame; Q[n] is the bit from channel slot n.
REQ-009 SHALL have port FRAME, output, 1 bit: one-cycle pulse; Q holds a newly completed frame.
REQ-010 SHALL have port CH, output, 3 bits: slot index the next accepted bit is written to.
REQ-011 SHALL have port PERR, output, 1 bit: parity-error pulse, coincident with FRAME.

Function
REQ-012 SHALL hold accepted bits in an 8-bit staging register; Q SHALL change only on frame completion (double-buffered, never partially updated).
REQ-013 SHALL implement states IDLE, DATA, PAR (PAR exists only per REQ-024).
REQ-014 IDLE: on accepted bit, write DIN to staging[0], CH<=1, go DATA; SYNC value irrelevant.
REQ-015 DATA: on accepted bit with SYNC=0, write DIN to staging[CH], CH<=CH+1.
REQ-016 DATA: on accepted bit with SYNC=1, discard partial frame, write DIN to staging[0], CH<=1; no FRAME pulse.
REQ-017 Accepted bit at CH=7 (SYNC=0), macro off: on that same edge Q<={DIN,staging[6:0]}, CH wraps to 0, stay DATA; FRAME=1 for the following cycle only.
REQ-018 Edges with EN=1 or DVALID=0: staging, CH, Q, state unchanged; FRAME and PERR SHALL be 0.
REQ-019 Latency: Q and FRAME valid one clock after the edge accepting the last bit of a frame; back-to-back frames with DVALID held high SHALL produce a FRAME pulse every 8 cycles (9 with macro).
REQ-020 EN rising mid-frame SHALL pause, not abort; reception resumes at the held CH.
REQ-021 RST asserted mid-frame SHALL discard the partial frame regardless of EN.

Reset
REQ-022 On RST=1 at a rising edge: Q=8'h00, staging=8'h00, CH=3'd0, FRAME=0, PERR=0, state=IDLE; RST SHALL dominate EN, DVALID, SYNC.
REQ-023 First accepted bit after reset SHALL be slot 0.

Configuration
REQ-024 Macro TDM_DEMUX8_PARITY_EN defined: frame is 9 slots; after slot 7 go PAR with CH=0 but Q not yet updated; the accepted bit in PAR is even parity over slots 0-7; on that edge Q<=staging, FRAME=1 next cycle, PERR=1 next cycle if XOR of 8 data bits and parity bit is 1; Q SHALL update even on error; SYNC=1 in PAR SHALL restart per REQ-016.
REQ-025 Macro not defined: PAR state and parity logic absent, 8-slot frames, PERR SHALL be tied 0.

Verification
REQ-026 RST, then EN=0, DVALID=1, SYNC=1 on first bit, DIN slots 0..7 = 1,0,1,1,0,0,1,0 -> Q=8'h4D one cycle after 8th bit, FRAME single pulse, CH=0.
REQ-027 Two frames 8'hFF then 8'h00 back-to-back, DVALID constant -> FRAME pulses 8 cycles apart, Q=8'hFF then 8'h00, no intermediate Q values.
REQ-028 Send 5 bits, then SYNC=1 with new frame 8'hA5 -> no FRAME for partial frame, Q=8'hA5 after 8 bits of new frame.
REQ-029 Mid-frame at CH=3, EN=1 for 4 cycles while DIN/DVALID toggle -> CH stays 3, Q unchanged, frame completes correctly after EN=0.
REQ-030 RST asserted at CH=6 with EN=1 -> next cycle Q=0, CH=0, FRAME=0; next accepted bit is slot 0.
REQ-031 Macro on: frame 8'h4D with parity 0 -> FRAME=1, PERR=0; parity 1 -> FRAME=1, PERR=1, Q=8'h4D; macro off -> PERR constant 0.

Source files
------------

// File: rtl/tdm_demux8.sv
// tdm_demux8: serial time-division demultiplexer, one bit per channel slot.
// Accepted bits collect in a staging register; Q is reloaded only when a full
// frame completes, so it never shows a partially received frame.
// Optional build macro TDM_DEMUX8_PARITY_EN adds a ninth (even parity) slot
// and drives PERR; without it frames are 8 slots and PERR is tied low.
//
// state | meaning
// IDLE  | after reset, waiting for the first accepted bit (always slot 0)
// DATA  | receiving data slots; CH is the slot the next bit lands in
// PAR   | all 8 data slots held, waiting for the parity bit (macro only)
module tdm_demux8 (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       DIN,
  input  logic       DVALID,
  input  logic       SYNC,
  output logic [7:0] Q,
  output logic       FRAME,
  output logic [2:0] CH,
  output logic       PERR
);

`ifdef TDM_DEMUX8_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1} state_t;
`endif

  state_t     state, state_nxt;
  logic [7:0] stg, stg_nxt;
  logic [7:0] q_nxt;
  logic [2:0] ch_nxt;
  logic       frame_nxt;
  logic       accept;
`ifdef TDM_DEMUX8_PARITY_EN
  logic       perr_nxt;
`endif

  // EN is active-low; a bit only counts when DVALID qualifies it too.
  assign accept = ~EN & DVALID;

  // State, staging and output registers; reset wins over every other input.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      stg   <= 8'h00;
      Q     <= 8'h00;
      CH    <= 3'd0;
      FRAME <= 1'b0;
`ifdef TDM_DEMUX8_PARITY_EN
      PERR  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      stg   <= stg_nxt;
      Q     <= q_nxt;
      CH    <= ch_nxt;
      FRAME <= frame_nxt;
`ifdef TDM_DEMUX8_PARITY_EN
      PERR  <= perr_nxt;
`endif
    end
  end

`ifndef TDM_DEMUX8_PARITY_EN
  assign PERR = 1'b0;
`endif

  // Next-state and datapath decode; FRAME/PERR default low so they pulse once.
  always_comb begin
    state_nxt = state;
    stg_nxt   = stg;
    q_nxt     = Q;
    ch_nxt    = CH;
    frame_nxt = 1'b0;
`ifdef TDM_DEMUX8_PARITY_EN
    perr_nxt  = 1'b0;
`endif
    if (accept) begin
      case (state)
        IDLE: begin
          stg_nxt[0] = DIN;
          ch_nxt     = 3'd1;
          state_nxt  = DATA;
        end
        DATA: begin
          if (SYNC) begin
            // Frame marker mid-frame: drop what was collected and restart.
            stg_nxt[0] = DIN;
            ch_nxt     = 3'd1;
          end else if (CH == 3'd7) begin
            stg_nxt[7] = DIN;
            ch_nxt     = 3'd0;
`ifdef TDM_DEMUX8_PARITY_EN
            state_nxt  = PAR;
`else
            q_nxt      = {DIN, stg[6:0]};
            frame_nxt  = 1'b1;
`endif
          end else begin
            stg_nxt[CH] = DIN;
            ch_nxt      = CH + 3'd1;
          end
        end
`ifdef TDM_DEMUX8_PARITY_EN
        PAR: begin
          if (SYNC) begin
            stg_nxt[0] = DIN;
            ch_nxt     = 3'd1;
            state_nxt  = DATA;
          end else begin
            // Q takes the frame even when parity is wrong; PERR flags it.
            q_nxt     = stg;
            frame_nxt = 1'b1;
            perr_nxt  = (^stg) ^ DIN;
            ch_nxt    = 3'd0;
            state_nxt = DATA;
          end
        end
`endif
        default: begin
          state_nxt = IDLE;
          ch_nxt    = 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux8.sv
// Bench for tdm_demux8: directed vector table, hand-written corner sequences
// and a random run, all compared against a slot-counting frame model.
module tb_tdm_demux8;

`ifdef TDM_DEMUX8_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic       DIN = 1'b0;
  logic       DVALID = 1'b0;
  logic       SYNC = 1'b0;
  logic [7:0] Q;
  logic       FRAME;
  logic [2:0] CH;
  logic       PERR;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  tdm_demux8 dut (
    .CLK(CLK), .RST(RST), .EN(EN), .DIN(DIN), .DVALID(DVALID), .SYNC(SYNC),
    .Q(Q), .FRAME(FRAME), .CH(CH), .PERR(PERR)
  );

  always #5 CLK = ~CLK;

  // Reference model: frame contents as a list of received bits.
  bit         mbuf[9];
  int         mn = 0;
  logic [7:0] mq = 8'h00;
  bit         mf = 1'b0;
  bit         mp = 1'b0;

  task automatic model_step(input bit rst, input bit en, input bit dv,
                            input bit sync, input bit din);
    bit par;
    mf = 1'b0;
    mp = 1'b0;
    if (rst) begin
      mq = 8'h00;
      mn = 0;
    end else if (!en && dv) begin
      if (mn == 0 || sync) begin
        mbuf[0] = din;
        mn = 1;
      end else begin
        mbuf[mn] = din;
        mn++;
        if (mn == FL) begin
          for (int i = 0; i < 8; i++) mq[i] = mbuf[i];
          par = 1'b0;
          for (int i = 0; i < FL; i++) par ^= mbuf[i];
          mf = 1'b1;
`ifdef TDM_DEMUX8_PARITY_EN
          mp = par;
`endif
          mn = 0;
        end
      end
    end
  endtask

  function automatic logic [2:0] model_ch();
    return (mn >= 8) ? 3'd0 : 3'(mn);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic apply(input bit rst, input bit en, input bit dv,
                       input bit sync, input bit din);
    @(negedge CLK);
    RST = rst; EN = en; DVALID = dv; SYNC = sync; DIN = din;
    @(posedge CLK);
    #1;
    cyc++;
    model_step(rst, en, dv, sync, din);
  endtask

  task automatic step(input bit rst, input bit en, input bit dv,
                      input bit sync, input bit din);
    apply(rst, en, dv, sync, din);
    check("q", Q, mq);
    check("ch", {5'd0, CH}, {5'd0, model_ch()});
    check("frame", {7'd0, FRAME}, {7'd0, mf});
    check("perr", {7'd0, PERR}, {7'd0, mp});
  endtask

  task automatic send_byte(input logic [7:0] b, input bit first_sync);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, first_sync && i == 0, b[i]);
`ifdef TDM_DEMUX8_PARITY_EN
    step(1'b0, 1'b0, 1'b1, 1'b0, ^b);
`endif
  endtask

  typedef struct {
    bit rst, en, dv, sync, din;
    logic [7:0] q;
    bit f, p;
    logic [2:0] ch;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit rst, input bit en, input bit dv, input bit sync,
                     input bit din, input logic [7:0] q, input bit f,
                     input bit p, input logic [2:0] ch);
    vec_t v;
    v.rst = rst; v.en = en; v.dv = dv; v.sync = sync; v.din = din;
    v.q = q; v.f = f; v.p = p; v.ch = ch;
    vt.push_back(v);
  endtask

  initial begin
    int last_frame;
    int pulses;
    logic [7:0] b;

    // Reset, then frame 0x4D sent LSB-first as slots 0..7 = 1,0,1,1,0,0,1,0.
    add(1, 0, 0, 0, 0, 8'h00, 0, 0, 3'd0);
    add(0, 0, 1, 1, 1, 8'h00, 0, 0, 3'd1);
    add(0, 0, 1, 0, 0, 8'h00, 0, 0, 3'd2);
    add(0, 0, 1, 0, 1, 8'h00, 0, 0, 3'd3);
    add(0, 0, 1, 0, 1, 8'h00, 0, 0, 3'd4);
    add(0, 0, 1, 0, 0, 8'h00, 0, 0, 3'd5);
    add(0, 0, 1, 0, 0, 8'h00, 0, 0, 3'd6);
    add(0, 0, 1, 0, 1, 8'h00, 0, 0, 3'd7);
`ifdef TDM_DEMUX8_PARITY_EN
    add(0, 0, 1, 0, 0, 8'h00, 0, 0, 3'd0);
    add(0, 0, 1, 0, 0, 8'h4D, 1, 0, 3'd0);
    add(0, 0, 0, 0, 0, 8'h4D, 0, 0, 3'd0);
    // Same data with a wrong parity bit: Q still updates, PERR pulses.
    add(0, 0, 1, 1, 1, 8'h4D, 0, 0, 3'd1);
    add(0, 0, 1, 0, 0, 8'h4D, 0, 0, 3'd2);
    add(0, 0, 1, 0, 1, 8'h4D, 0, 0, 3'd3);
    add(0, 0, 1, 0, 1, 8'h4D, 0, 0, 3'd4);
    add(0, 0, 1, 0, 0, 8'h4D, 0, 0, 3'd5);
    add(0, 0, 1, 0, 0, 8'h4D, 0, 0, 3'd6);
    add(0, 0, 1, 0, 1, 8'h4D, 0, 0, 3'd7);
    add(0, 0, 1, 0, 0, 8'h4D, 0, 0, 3'd0);
    add(0, 0, 1, 0, 1, 8'h4D, 1, 1, 3'd0);
    add(0, 0, 0, 0, 0, 8'h4D, 0, 0, 3'd0);
`else
    add(0, 0, 1, 0, 0, 8'h4D, 1, 0, 3'd0);
    add(0, 0, 0, 0, 0, 8'h4D, 0, 0, 3'd0);
    add(0, 1, 1, 0, 1, 8'h4D, 0, 0, 3'd0);
`endif

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i].rst, vt[i].en, vt[i].dv, vt[i].sync, vt[i].din);
      check("vec_q", Q, vt[i].q);
      check("vec_ch", {5'd0, CH}, {5'd0, vt[i].ch});
      check("vec_frame", {7'd0, FRAME}, {7'd0, vt[i].f});
      check("vec_perr", {7'd0, PERR}, {7'd0, vt[i].p});
    end

    // Back-to-back 0xFF then 0x00 with DVALID held: pulses exactly FL apart.
    step(1, 0, 0, 0, 0);
    last_frame = -1;
    pulses = 0;
    for (int f = 0; f < 2; f++) begin
      b = (f == 0) ? 8'hFF : 8'h00;
      for (int i = 0; i < FL; i++) begin
        step(0, 0, 1, (i == 0), (i < 8) ? b[i] : ^b);
        if (FRAME) begin
          pulses++;
          check("b2b_q", Q, b);
          if (last_frame >= 0) check("b2b_gap", 8'(cyc - last_frame), 8'(FL));
          last_frame = cyc;
        end
      end
    end
    check("b2b_pulses", 8'(pulses), 8'd2);

    // Partial frame of 5 bits, then SYNC restarts with 0xA5.
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 1);
    send_byte(8'hA5, 1'b1);
    check("restart_q", Q, 8'hA5);
    step(0, 0, 0, 0, 0);

    // Pause at CH=3 for 4 cycles while DIN/DVALID toggle.
    b = 8'h3C;
    for (int i = 0; i < 3; i++) step(0, 0, 1, (i == 0), b[i]);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, i[0], 0, ~i[1]);
      check("pause_ch", {5'd0, CH}, 8'd3);
    end
    for (int i = 3; i < 8; i++) step(0, 0, 1, 0, b[i]);
`ifdef TDM_DEMUX8_PARITY_EN
    step(0, 0, 1, 0, ^b);
`endif
    check("pause_q", Q, 8'h3C);

    // Reset at CH=6 while EN holds the block frozen.
    for (int i = 0; i < 6; i++) step(0, 0, 1, (i == 0), 1);
    step(1, 1, 1, 0, 1);
    check("rst_q", Q, 8'h00);
    check("rst_ch", {5'd0, CH}, 8'd0);
    step(0, 0, 1, 0, 1);
    check("rst_slot0_ch", {5'd0, CH}, 8'd1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 150) == 0, ($urandom % 5) == 0, ($urandom % 4) != 0,
           ($urandom % 20) == 0, $urandom % 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
